if_id_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register for the 5-stage MIPS pipeline.
- Owns the PC and drives a synchronous-read instruction memory (1-cycle read latency).
- Presents the fetched instruction to ID.
- Consumes `stall` from the ID-stage hazard/forwarding unit and the ID-stage branch/jump redirect.
- Holds, flushes or advances the fetch stream, and counts bubbles.

---
 rtl/if_id_stage.sv | 178 +++++++++++++++++
 tb/tb_if_id_stage.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/if_id_stage.sv
// Instruction-fetch stage plus IF/ID pipeline register.
// Owns the fetch PC, drives a synchronous-read instruction memory and
// presents the fetched instruction to decode. It holds on stall, flushes on
// a taken redirect (when no delay slot is used) and counts bubbles into ID.
// When a redirect flushes the fetch stream, the slot after it (KILL) presents
// the target address again and inserts a second bubble. The target word then
// enters ID on the following edge with its own PC.
module if_id_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter int          DELAY_SLOT = 0,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      ID_Ins,
  output logic [31:0]      ID_PC,
  output logic [31:0]      ID_PC4,
  output logic             ID_valid,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_KILL = 2'd2
  } state_t;

  localparam logic KILL_EN = (DELAY_SLOT == 0) ? 1'b1 : 1'b0;

  // Saturating increment: stops at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == {CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  state_t           state_r;
  state_t           state_nxt_s;
  logic [31:0]      f_pc_r;
  logic [31:0]      imem_addr_s;
  logic [31:0]      target_s;
  logic             redirect_acc_s;
  logic [31:0]      id_ins_r;
  logic [31:0]      id_pc_r;
  logic             id_valid_r;
  logic [CNT_W-1:0] bubble_cnt_r;
  logic [31:0]      id_ins_nxt_s;
  logic [31:0]      id_pc_nxt_s;
  logic             id_valid_nxt_s;
  logic             bubble_s;
  logic             unused_rpc_lsb_s;

  // A stalled ID instruction has not resolved, so stall masks the redirect;
  // a bubble in ID cannot redirect either.
  assign redirect_acc_s   = redirect & ~stall & id_valid_r;
  assign target_s         = {redirect_pc[31:2], 2'b00};
  assign unused_rpc_lsb_s = ^redirect_pc[1:0];

  // Next-fetch address: re-read on boot/kill/stall, jump on redirect, else +4.
  always_comb begin
    imem_addr_s = f_pc_r;
    case (state_r)
      ST_BOOT: begin
        imem_addr_s = f_pc_r;
      end
      ST_KILL: begin
        // F_PC already holds the target; re-present it so it arrives next cycle.
        imem_addr_s = f_pc_r;
      end
      ST_RUN: begin
        if (stall) begin
          imem_addr_s = f_pc_r;
        end else if (redirect_acc_s) begin
          imem_addr_s = target_s;
        end else begin
          imem_addr_s = f_pc_r + 32'd4;
        end
      end
      default: begin
        imem_addr_s = f_pc_r;
      end
    endcase
  end

  // Fetch state sequencing: boot slot, normal run, killed wrong-path slot.
  always_comb begin
    state_nxt_s = ST_RUN;
    case (state_r)
      ST_BOOT: begin
        state_nxt_s = ST_RUN;
      end
      ST_RUN: begin
        if (redirect_acc_s && KILL_EN) begin
          state_nxt_s = ST_KILL;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_KILL: begin
        if (redirect_acc_s && KILL_EN) begin
          state_nxt_s = ST_KILL;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: begin
        state_nxt_s = ST_BOOT;
      end
    endcase
  end

  // IF/ID next value: hold on stall, bubble on boot/kill/flush, else advance.
  always_comb begin
    id_ins_nxt_s   = id_ins_r;
    id_pc_nxt_s    = id_pc_r;
    id_valid_nxt_s = id_valid_r;
    bubble_s       = 1'b0;
    if (stall) begin
      bubble_s = 1'b1;
    end else if ((state_r != ST_RUN) || (redirect_acc_s && KILL_EN)) begin
      id_ins_nxt_s   = 32'd0;
      id_pc_nxt_s    = f_pc_r;
      id_valid_nxt_s = 1'b0;
      bubble_s       = 1'b1;
    end else begin
      id_ins_nxt_s   = imem_rdata;
      id_pc_nxt_s    = f_pc_r;
      id_valid_nxt_s = 1'b1;
    end
  end

  // Fetch PC and state register; F_PC tracks the address memory just sampled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_BOOT;
      f_pc_r  <= RESET_PC;
    end else begin
      state_r <= state_nxt_s;
      f_pc_r  <= imem_addr_s;
    end
  end

  // IF/ID pipeline register and saturating bubble counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_ins_r     <= 32'd0;
      id_pc_r      <= 32'd0;
      id_valid_r   <= 1'b0;
      bubble_cnt_r <= {CNT_W{1'b0}};
    end else begin
      id_ins_r   <= id_ins_nxt_s;
      id_pc_r    <= id_pc_nxt_s;
      id_valid_r <= id_valid_nxt_s;
      if (bubble_s) begin
        bubble_cnt_r <= sat_inc(bubble_cnt_r);
      end else begin
        bubble_cnt_r <= bubble_cnt_r;
      end
    end
  end

  assign imem_addr  = imem_addr_s;
  assign ID_Ins     = id_ins_r;
  assign ID_PC      = id_pc_r;
  assign ID_PC4     = id_pc_r + 32'd4;
  assign ID_valid   = id_valid_r;
  assign bubble_cnt = bubble_cnt_r;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: one instance without delay slot (16-bit
// counter) and one with delay slot (4-bit counter) share the same stimulus.
// Expected ID contents are queued when a step is driven and popped after the edge.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;

  logic [31:0] addr0, rdata0, ins0, pc0, pc40;
  logic        val0;
  logic [15:0] cnt0;
  logic [31:0] addr1, rdata1, ins1, pc1, pc41;
  logic        val1;
  logic [3:0]  cnt1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic        v;
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] cnt;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   mcnt0 = 0;
  int   mcnt1 = 0;
  int   stepno = 0;

  if_id_stage #(.RESET_PC(32'h0000_3000), .DELAY_SLOT(0), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_addr(addr0), .imem_rdata(rdata0),
    .ID_Ins(ins0), .ID_PC(pc0), .ID_PC4(pc40), .ID_valid(val0),
    .bubble_cnt(cnt0));

  if_id_stage #(.RESET_PC(32'h0000_3000), .DELAY_SLOT(1), .CNT_W(4)) u1 (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_addr(addr1), .imem_rdata(rdata1),
    .ID_Ins(ins1), .ID_PC(pc1), .ID_PC4(pc41), .ID_valid(val1),
    .bubble_cnt(cnt1));

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Synchronous-read instruction memories, one cycle of latency.
  always @(posedge clk) begin
    rdata0 <= mem_f(addr0);
    rdata1 <= mem_f(addr1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic st, input logic rd, input logic [31:0] rpc);
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    #1;
  endtask

  task automatic step(input logic st, input logic rd, input logic [31:0] rpc,
                      input logic v0, input logic [31:0] p0,
                      input logic v1, input logic [31:0] p1);
    exp_t e;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    stepno++;
    if (st || !v0) mcnt0 = (mcnt0 == 65535) ? 65535 : mcnt0 + 1;
    if (st || !v1) mcnt1 = (mcnt1 == 15) ? 15 : mcnt1 + 1;
    e.tag = $sformatf("u0_step%0d", stepno);
    e.v = v0; e.pc = p0; e.ins = v0 ? mem_f(p0) : 32'd0; e.cnt = mcnt0;
    q0.push_back(e);
    e.tag = $sformatf("u1_step%0d", stepno);
    e.v = v1; e.pc = p1; e.ins = v1 ? mem_f(p1) : 32'd0; e.cnt = mcnt1;
    q1.push_back(e);
    @(posedge clk);
    #1;
    e = q0.pop_front();
    chk({e.tag, "_valid"}, {31'd0, val0}, {31'd0, e.v});
    chk({e.tag, "_pc"}, pc0, e.pc);
    chk({e.tag, "_pc4"}, pc40, e.pc + 32'd4);
    chk({e.tag, "_ins"}, ins0, e.ins);
    chk({e.tag, "_cnt"}, {16'd0, cnt0}, e.cnt);
    e = q1.pop_front();
    chk({e.tag, "_valid"}, {31'd0, val1}, {31'd0, e.v});
    chk({e.tag, "_pc"}, pc1, e.pc);
    chk({e.tag, "_pc4"}, pc41, e.pc + 32'd4);
    chk({e.tag, "_ins"}, ins1, e.ins);
    chk({e.tag, "_cnt"}, {28'd0, cnt1}, e.cnt);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_u0_valid"}, {31'd0, val0}, 32'd0);
    chk({tag, "_u0_pc"}, pc0, 32'd0);
    chk({tag, "_u0_ins"}, ins0, 32'd0);
    chk({tag, "_u0_cnt"}, {16'd0, cnt0}, 32'd0);
    chk({tag, "_u0_addr"}, addr0, 32'h0000_3000);
    chk({tag, "_u1_valid"}, {31'd0, val1}, 32'd0);
    chk({tag, "_u1_pc"}, pc1, 32'd0);
    chk({tag, "_u1_cnt"}, {28'd0, cnt1}, 32'd0);
    chk({tag, "_u1_addr"}, addr1, 32'h0000_3000);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    @(posedge clk); #1;
    chk_cleared("reset");
    chk("reset_pc4", pc40, 32'd4);

    // Release reset mid-cycle: boot bubble, then sequential fetch.
    rst = 1'b0; mcnt0 = 0; mcnt1 = 0;
    step(1'b0, 1'b0, 32'd0, 1'b0, 32'h3000, 1'b0, 32'h3000);
    chk("run_addr_u0", addr0, 32'h3004);
    step(1'b0, 1'b0, 32'd0, 1'b1, 32'h3000, 1'b1, 32'h3000);
    step(1'b0, 1'b0, 32'd0, 1'b1, 32'h3004, 1'b1, 32'h3004);
    step(1'b0, 1'b0, 32'd0, 1'b1, 32'h3008, 1'b1, 32'h3008);

    // Three-cycle stall with ID_PC = 0x3008: fetch address stays 0x300C.
    drive(1'b1, 1'b0, 32'd0);
    chk("stall_addr_u0", addr0, 32'h300C);
    chk("stall_addr_u1", addr1, 32'h300C);
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 32'd0, 1'b1, 32'h3008, 1'b1, 32'h3008);
    chk("stall_addr_held", addr0, 32'h300C);
    step(1'b0, 1'b0, 32'd0, 1'b1, 32'h300C, 1'b1, 32'h300C);
    step(1'b0, 1'b0, 32'd0, 1'b1, 32'h3010, 1'b1, 32'h3010);

    // Redirect to 0x3103 (low bits masked) while ID_PC = 0x3010.
    drive(1'b0, 1'b1, 32'h3103);
    chk("redir_addr_u0", addr0, 32'h3100);
    chk("redir_addr_u1", addr1, 32'h3100);
    step(1'b0, 1'b1, 32'h3103, 1'b0, 32'h3014, 1'b1, 32'h3014);
    drive(1'b0, 1'b0, 32'd0);
    chk("kill_addr_u0", addr0, 32'h3100);
    chk("ds_addr_u1", addr1, 32'h3104);
    step(1'b0, 1'b0, 32'd0, 1'b0, 32'h3100, 1'b1, 32'h3100);
    step(1'b0, 1'b0, 32'd0, 1'b1, 32'h3100, 1'b1, 32'h3104);

    // Stall together with redirect: redirect ignored, then taken once stall drops.
    drive(1'b1, 1'b1, 32'h3200);
    chk("stallredir_addr_u0", addr0, 32'h3104);
    chk("stallredir_addr_u1", addr1, 32'h3108);
    step(1'b1, 1'b1, 32'h3200, 1'b1, 32'h3100, 1'b1, 32'h3104);
    drive(1'b0, 1'b1, 32'h3200);
    chk("late_redir_addr_u0", addr0, 32'h3200);
    chk("late_redir_addr_u1", addr1, 32'h3200);
    step(1'b0, 1'b1, 32'h3200, 1'b0, 32'h3104, 1'b1, 32'h3108);
    step(1'b0, 1'b0, 32'd0, 1'b0, 32'h3200, 1'b1, 32'h3200);
    step(1'b0, 1'b0, 32'd0, 1'b1, 32'h3200, 1'b1, 32'h3204);

    // Long stall drives the 4-bit counter into saturation.
    for (int i = 0; i < 20; i++)
      step(1'b1, 1'b0, 32'd0, 1'b1, 32'h3200, 1'b1, 32'h3204);
    chk("sat_u1", {28'd0, cnt1}, 32'd15);

    // Asynchronous reset in the middle of a stalled cycle.
    stall = 1'b1;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk_cleared("async_rst");
    @(posedge clk); #1;
    rst = 1'b0; stall = 1'b0; mcnt0 = 0; mcnt1 = 0;
    step(1'b0, 1'b0, 32'd0, 1'b0, 32'h3000, 1'b0, 32'h3000);
    step(1'b0, 1'b0, 32'd0, 1'b1, 32'h3000, 1'b1, 32'h3000);
    step(1'b0, 1'b0, 32'd0, 1'b1, 32'h3004, 1'b1, 32'h3004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
